// File: rtl/instr_dispatch.sv
// instr_dispatch: latches a 22-bit instruction on a button press and runs a fixed
// SEND/HOLD/DONE handshake to the register file. Optional debounce: DISPATCH_DEBOUNCE_EN.
module instr_dispatch #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic [21:0] instr,
    output logic [2:0]  opcode,
    output logic [3:0]  D1,
    output logic [3:0]  r2,
    output logic [3:0]  r3,
    output logic [6:0]  entrada,
    output logic        enviar,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic        sync1_q;
    logic        sync2_q;
    logic        deb;
    logic        prev_q;
    logic        press;

    logic [1:0]  state_q, state_d;
    logic        hold_q, hold_d;
    logic [21:0] fields_q, fields_d;
    logic        enviar_q, enviar_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Sync flops and the edge detector reset high so a button held through reset
    // never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbour (the sync chain depends on it).
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= deb;
        end
    end

`ifdef DISPATCH_DEBOUNCE_EN
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        deb_q, deb_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the ifs leaves it unassigned and infers a latch.
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb = deb_q;
`else
    logic [15:0] unused_debounce;
    assign unused_debounce = 16'(DEBOUNCE_CYCLES);
    assign deb = sync2_q;
`endif

    assign press = deb & ~prev_q;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        fields_d = fields_q;
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d  = ST_SEND;
                    fields_d = instr;
                end
            end
            ST_SEND: begin
                state_d = ST_HOLD;
                hold_d  = 1'b0;
            end
            ST_HOLD: begin
                if (hold_q) begin
                    state_d = ST_DONE;
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear as registers.
        enviar_d = (state_d == ST_SEND);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hold_q   <= 1'b0;
            fields_q <= '0;
            enviar_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            fields_q <= fields_d;
            enviar_q <= enviar_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign {opcode, D1, r2, r3, entrada} = fields_q;
    assign enviar = enviar_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: directed scenarios plus random button
// traffic, compared every cycle against a phase-counting reference model.
module tb_instr_dispatch;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn;
    logic [21:0] instr;
    logic [2:0]  opcode;
    logic [3:0]  D1, r2, r3;
    logic [6:0]  entrada;
    logic        enviar, busy, done;

    instr_dispatch #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .btn(btn), .instr(instr),
        .opcode(opcode), .D1(D1), .r2(r2), .r3(r3), .entrada(entrada),
        .enviar(enviar), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: button view and a dispatch phase (-1 idle, 0 send, 1-2 hold, 3 done).
    logic        m_s1, m_s2, m_deb, m_prev;
    int          m_run;
    int          m_phase;
    logic [21:0] m_fields;

    // Receiver register file, cleared by an INIT (opcode 110) dispatch.
    logic [15:0] rf [16];

    int cyc, n_env, n_busy, n_done, t_env, t_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic b, input logic r, input logic [21:0] ins);
        logic press;
        if (r) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1; m_prev = 1'b1;
            m_run = 0; m_phase = -1; m_fields = '0;
        end else begin
            press = m_deb && !m_prev;
            if (m_phase >= 0) begin
                m_phase = (m_phase == 3) ? -1 : m_phase + 1;
            end else if (press) begin
                m_fields = ins;
                m_phase  = 0;
            end
`ifdef DISPATCH_DEBOUNCE_EN
            m_prev = m_deb;
            if (m_s2 != m_deb) begin
                m_run++;
                if (m_run == DC) begin
                    m_deb = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
`else
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = b;
            m_deb  = m_s2;
`endif
        end
    endtask

    task automatic clear_stats();
        cyc = 0; n_env = 0; n_busy = 0; n_done = 0; t_env = -1; t_done = -1;
    endtask

    task automatic cycle(input logic b, input logic r, input logic [21:0] ins);
        @(negedge clk);
        btn = b; reset = r; instr = ins;
        @(posedge clk);
        model_step(b, r, ins);
        #1;
        check("enviar",  32'(enviar),  32'(m_phase == 0));
        check("busy",    32'(busy),    32'(m_phase >= 0));
        check("done",    32'(done),    32'(m_phase == 3));
        check("opcode",  32'(opcode),  32'(m_fields[21:19]));
        check("D1",      32'(D1),      32'(m_fields[18:15]));
        check("r2",      32'(r2),      32'(m_fields[14:11]));
        check("r3",      32'(r3),      32'(m_fields[10:7]));
        check("entrada", 32'(entrada), 32'(m_fields[6:0]));
        if (enviar) begin
            n_env++;
            if (t_env < 0) t_env = cyc;
            if (opcode == 3'b110) begin
                for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
            end
        end
        if (busy) n_busy++;
        if (done) begin
            n_done++;
            if (t_done < 0) t_done = cyc;
        end
        cyc++;
    endtask

    initial begin
        logic [21:0] first;
        logic [21:0] cur;
        logic        sticky;
        logic        b;
        logic        r;
        int          guard;
        int          len;
        int          nonzero;

        reset = 1'b1; btn = 1'b0; instr = '0;
        m_phase = -1; m_fields = '0;
        m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1; m_prev = 1'b1; m_run = 0;
        for (int i = 0; i < 16; i++) rf[i] = 16'(i + 1);
        clear_stats();

        // Reset state
        cycle(1'b0, 1'b1, 22'h0);
        cycle(1'b0, 1'b1, 22'h0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_enviar", 32'(enviar), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        repeat (12) cycle(1'b0, 1'b0, 22'h0);

        // Long press of 22'h0A5A5A
        clear_stats();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 22'h0A5A5A);
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 22'h0A5A5A);
        check("p1_env_count",  32'(n_env),  32'd1);
        check("p1_busy_count", 32'(n_busy), 32'd4);
        check("p1_done_delay", 32'(t_done - t_env), 32'd3);
        check("p1_opcode",  32'(opcode),  32'h1);
        check("p1_D1",      32'(D1),      32'h4);
        check("p1_r2",      32'(r2),      32'hB);
        check("p1_r3",      32'(r3),      32'h4);
        check("p1_entrada", 32'(entrada), 32'h5A);

        // Three-cycle glitch
        clear_stats();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 22'h123456);
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 22'h123456);
`ifdef DISPATCH_DEBOUNCE_EN
        check("glitch_env_count",  32'(n_env),  32'd0);
        check("glitch_busy_count", 32'(n_busy), 32'd0);
`else
        check("glitch_env_count",  32'(n_env),  32'd1);
`endif

        // Second press while busy, instr changed during HOLD
        clear_stats();
        first = 22'($urandom);
        sticky = 1'b0;
        for (int i = 0; i < 24; i++) begin
            b = (i < 3) || (i >= 4 && i < 12);
            if (m_phase >= 1) sticky = 1'b1;
            cur = sticky ? 22'h3FFFFF : first;
            cycle(b, 1'b0, cur);
        end
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 22'h3FFFFF);
        check("busy_press_env_count", 32'(n_env), 32'd1);
        check("busy_press_fields", 32'({opcode, D1, r2, r3, entrada}), 32'(first));

        // Reset in the cycle after enviar, button held across reset
        clear_stats();
        cur = 22'($urandom);
        guard = 0;
        do begin
            cycle(1'b1, 1'b0, cur);
            guard++;
        end while (n_env == 0 && guard < 40);
        check("rst_abort_env_seen", 32'(n_env), 32'd1);
        cycle(1'b1, 1'b0, cur);
        cycle(1'b1, 1'b1, cur);
        check("rst_abort_busy",    32'(busy),    32'd0);
        check("rst_abort_entrada", 32'(entrada), 32'd0);
        check("rst_abort_D1",      32'(D1),      32'd0);
        clear_stats();
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, cur);
        check("rst_held_env", 32'(n_env),  32'd0);
        check("rst_no_done",  32'(n_done), 32'd0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, cur);
        for (int i = 0; i < 8; i++)  cycle(1'b1, 1'b0, cur);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, cur);
        check("rst_repress_env", 32'(n_env), 32'd1);

        // INIT opcode 110: same timing, receiver cleared
        for (int i = 0; i < 16; i++) rf[i] = 16'(16'h1000 + i);
        clear_stats();
        cur = 22'($urandom);
        cur[21:19] = 3'b110;
        for (int i = 0; i < 8; i++)  cycle(1'b1, 1'b0, cur);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, cur);
        check("init_env_count",  32'(n_env),  32'd1);
        check("init_busy_count", 32'(n_busy), 32'd4);
        check("init_done_delay", 32'(t_done - t_env), 32'd3);
        nonzero = 0;
        for (int i = 0; i < 16; i++) if (rf[i] != 16'h0000) nonzero++;
        check("init_rf_cleared", 32'(nonzero), 32'd0);

        // Single-cycle button pulse latency
        clear_stats();
        cycle(1'b1, 1'b0, 22'h2ABCDE);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 22'h2ABCDE);
`ifdef DISPATCH_DEBOUNCE_EN
        check("pulse1_env_count", 32'(n_env), 32'd0);
`else
        check("pulse1_env_count", 32'(n_env), 32'd1);
        check("pulse1_env_time",  32'(t_env), 32'd2);
`endif

        // Random button runs, random instr, rare reset
        for (int k = 0; k < 60; k++) begin
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) begin
                r = ($urandom_range(0, 99) == 0);
                cycle(b, r, 22'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
